// File: rtl/p2s_tx.sv
// p2s_tx: MSB-first parallel-to-serial transmitter with a
// valid/ready word input and a mid-bit sample strobe.
module p2s_tx #(
  parameter int WIDTH = 16,
  parameter int DIV   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     ser_out,
  output logic                     ser_en,
  output logic                     busy,
  output logic                     done
);

  localparam int LW = $clog2(WIDTH);
  localparam int DW = 8;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_MID  = DW'(DIV / 2);

  if (DIV < 2 || DIV > 255) begin : g_div_chk
    $error("p2s_tx: DIV out of range");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [LW-1:0]    bit_idx_q, bit_idx_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic             ser_out_q, ser_out_d;

  logic [LW-1:0]    first_idx;
  logic [LW-1:0]    next_idx;

  // len of zero means a full-width frame
  assign first_idx = (in_len == '0) ? LW'(WIDTH - 1)
                                    : in_len - LW'(1);
  assign next_idx  = bit_idx_q - LW'(1);

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bit_idx_d = bit_idx_q;
    div_cnt_d = div_cnt_q;
    ser_out_d = ser_out_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d    = in_data;
          bit_idx_d = first_idx;
          div_cnt_d = '0;
          ser_out_d = in_data[first_idx];
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_idx_q == '0) begin
            ser_out_d = 1'b0;
            state_d   = DONE;
          end else begin
            bit_idx_d = next_idx;
            ser_out_d = data_q[next_idx];
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      DONE: begin
        ser_out_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        ser_out_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      bit_idx_q <= '0;
      div_cnt_q <= '0;
      ser_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      bit_idx_q <= bit_idx_d;
      div_cnt_q <= div_cnt_d;
      ser_out_q <= ser_out_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign ser_out  = ser_out_q;
  // strobe sits mid-bit, well after ser_out has settled
  assign ser_en   = (state_q == SHIFT) && (div_cnt_q == DIV_MID);

endmodule
